// File: rtl/tile_loader_pkg.sv
// Shared types and address-field layout for the tile loader.
// The three write address formats (kernel, input, overlap) are built from these field widths.
package tile_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KERNEL,
        LOAD_INPUT,
        LOAD_OVERLAP,
        READY
    } state_t;

    localparam int ADDR_W     = 16;
    localparam int BANK_BIT   = 15;
    localparam int CNT_W      = 8;
    localparam int CNT_LEVELS = 4;

    localparam int INCH_W     = 1;
    localparam int K_OUTCH_W  = 4;
    localparam int K_KX_W     = 2;
    localparam int K_KY_W     = 2;
    localparam int K_KX_SH    = K_OUTCH_W;
    localparam int K_KY_SH    = K_KX_SH + K_KX_W;
    localparam int K_INCH_SH  = K_KY_SH + K_KY_W;

    localparam int IN_X_W     = 6;
    localparam int IN_Y_W     = 7;
    localparam int IN_Y_SH    = IN_X_W;
    localparam int IN_INCH_SH = IN_X_W + IN_Y_W;

    localparam int OV_Y_W     = 7;
    localparam int OV_INCH_SH = OV_Y_W;

    // Place a counter value into an address field of the given width.
    function automatic logic [ADDR_W-1:0] field(input logic [CNT_W-1:0] v, input int width,
                                                input int shift);
        logic [ADDR_W-1:0] mask;
        mask = (ADDR_W'(1) << width) - ADDR_W'(1);
        return (ADDR_W'(v) & mask) << shift;
    endfunction

endpackage

// File: rtl/nested_counter.sv
// Cascaded multi-level counter; level 0 is fastest, each level wraps at its max_val.
// 'last' flags the final combination so the caller can change phase on the same edge.
module nested_counter #(
    parameter int LEVELS = 4,
    parameter int W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       clear,
    input  logic                       en,
    input  logic [LEVELS-1:0][W-1:0]   max_val,
    output logic [LEVELS-1:0][W-1:0]   count,
    output logic                       last
);

    logic [LEVELS-1:0] at_max;
    logic [LEVELS-1:0] carry;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        at_max = '0;
        carry  = '0;
        for (int i = 0; i < LEVELS; i++) begin
            at_max[i] = (count[i] == max_val[i]);
        end
        carry[0] = 1'b1;
        for (int i = 1; i < LEVELS; i++) begin
            carry[i] = carry[i-1] & at_max[i-1];
        end
    end

    assign last = &at_max;

    // NOTE: sequential state uses non-blocking assignments so all levels update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_in || clear) begin
            count <= '0;
        end else if (en) begin
            for (int i = 0; i < LEVELS; i++) begin
                if (carry[i]) begin
                    count[i] <= at_max[i] ? '0 : count[i] + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tile_loader.sv
// Streams one tile (kernel, input rows, right-overlap column) from an upstream source into
// chip memories, zero-filling padding elements without consuming source words.
module tile_loader
    import tile_loader_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16,
    parameter int TILE_W        = 64,
    parameter int TILE_H        = 128,
    parameter int IN_CH         = 2,
    parameter int OUT_CH        = 16,
    parameter int KERNEL_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic [7:0]               valid_rows,
    input  logic                     overlap_present,
    input  logic [IO_DATA_WIDTH-1:0] src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic [ADDR_W-1:0]        a_input,
    output logic [IO_DATA_WIDTH-1:0] b_input,
    output logic                     int_mem_we,
    output logic                     overlap_cache_we,
    output logic                     b_zero,
    output logic                     data_ready,
    input  logic                     fsm_done,
    output logic                     busy
);

    state_t                              state;
    logic [7:0]                          rows_q;
    logic                                overlap_q;
    logic [CNT_LEVELS-1:0][CNT_W-1:0]    cnt;
    logic [CNT_LEVELS-1:0][CNT_W-1:0]    cnt_max;
    logic                                cnt_last;
    logic                                loading;
    logic                                pad;
    logic                                advance;
    logic                                start_ok;
    logic [ADDR_W-1:0]                   addr;

    // One counter is reused by every phase; the per-phase limits select its shape.
    always_comb begin
        cnt_max = '0;
        addr    = '0;
        pad     = 1'b0;
        case (state)
            LOAD_KERNEL: begin
                cnt_max[0] = CNT_W'(OUT_CH - 1);
                cnt_max[1] = CNT_W'(KERNEL_SIZE - 1);
                cnt_max[2] = CNT_W'(KERNEL_SIZE - 1);
                cnt_max[3] = CNT_W'(IN_CH - 1);
                addr = (ADDR_W'(1) << BANK_BIT)
                     | field(cnt[3], INCH_W, K_INCH_SH)
                     | field(cnt[2], K_KY_W, K_KY_SH)
                     | field(cnt[1], K_KX_W, K_KX_SH)
                     | field(cnt[0], K_OUTCH_W, 0);
            end
            LOAD_INPUT: begin
                cnt_max[0] = CNT_W'(TILE_W - 1);
                cnt_max[1] = CNT_W'(TILE_H - 1);
                cnt_max[2] = CNT_W'(IN_CH - 1);
                addr = field(cnt[2], INCH_W, IN_INCH_SH)
                     | field(cnt[1], IN_Y_W, IN_Y_SH)
                     | field(cnt[0], IN_X_W, 0);
                pad  = (cnt[1] >= rows_q);
            end
            LOAD_OVERLAP: begin
                cnt_max[0] = CNT_W'(TILE_H - 1);
                cnt_max[1] = CNT_W'(IN_CH - 1);
                addr = field(cnt[1], INCH_W, OV_INCH_SH)
                     | field(cnt[0], OV_Y_W, 0);
                pad  = (cnt[0] >= rows_q) || !overlap_q;
            end
            default: ;
        endcase
    end

    assign loading   = (state == LOAD_KERNEL) || (state == LOAD_INPUT) || (state == LOAD_OVERLAP);
    assign advance   = loading && (pad || src_valid);
    assign src_ready = loading && !pad;
    assign start_ok  = (state == IDLE) && start;
    assign busy      = (state != IDLE);

    nested_counter #(
        .LEVELS (CNT_LEVELS),
        .W      (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_in  (rst_in),
        .clear   (start_ok),
        .en      (advance),
        .max_val (cnt_max),
        .count   (cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state            <= IDLE;
            rows_q           <= '0;
            overlap_q        <= 1'b0;
            a_input          <= '0;
            b_input          <= '0;
            int_mem_we       <= 1'b0;
            overlap_cache_we <= 1'b0;
            b_zero           <= 1'b0;
            data_ready       <= 1'b0;
        end else begin
            int_mem_we       <= 1'b0;
            overlap_cache_we <= 1'b0;
            b_zero           <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q    <= valid_rows;
                        overlap_q <= overlap_present;
                        state     <= LOAD_KERNEL;
                    end
                end
                LOAD_KERNEL, LOAD_INPUT, LOAD_OVERLAP: begin
                    if (advance) begin
                        a_input          <= addr;
                        b_input          <= pad ? '0 : src_data;
                        b_zero           <= pad;
                        int_mem_we       <= (state != LOAD_OVERLAP);
                        overlap_cache_we <= (state == LOAD_OVERLAP);
                        if (cnt_last) begin
                            state <= (state == LOAD_KERNEL) ? LOAD_INPUT :
                                     (state == LOAD_INPUT)  ? LOAD_OVERLAP : READY;
                        end
                    end
                end
                READY: begin
                    // The first READY cycle carries the final write, so data_ready lags it by one.
                    if (fsm_done) begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                    end else begin
                        data_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_loader.sv
// Scoreboard bench for tile_loader: the expected write stream is queued at start and
// popped against every observed write strobe.
module tb_tile_loader;

    localparam int IN_CH  = 2;
    localparam int OUT_CH = 16;
    localparam int KS     = 3;
    localparam int TW     = 64;
    localparam int TH     = 128;

    logic        clk;
    logic        rst_in;
    logic        start;
    logic [7:0]  valid_rows;
    logic        overlap_present;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] a_input;
    logic [15:0] b_input;
    logic        int_mem_we;
    logic        overlap_cache_we;
    logic        b_zero;
    logic        data_ready;
    logic        fsm_done;
    logic        busy;

    tile_loader #(
        .IO_DATA_WIDTH (16),
        .TILE_W        (TW),
        .TILE_H        (TH),
        .IN_CH         (IN_CH),
        .OUT_CH        (OUT_CH),
        .KERNEL_SIZE   (KS)
    ) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .start            (start),
        .valid_rows       (valid_rows),
        .overlap_present  (overlap_present),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .a_input          (a_input),
        .b_input          (b_input),
        .int_mem_we       (int_mem_we),
        .overlap_cache_we (overlap_cache_we),
        .b_zero           (b_zero),
        .data_ready       (data_ready),
        .fsm_done         (fsm_done),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [34:0] exp_q[$];
    int          n_writes, n_input_wr, n_overlap_wr;
    int          first_wr, last_wr, dr_cyc, prev_k_cyc, gap_err, word_idx;
    logic [15:0] first_addr;
    bit          tog_mode, tog;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] word(input int k);
        return 16'(k) ^ 16'hA5C3;
    endfunction

    task automatic arm();
        n_writes = 0; n_input_wr = 0; n_overlap_wr = 0;
        first_wr = -1; last_wr = -1; dr_cyc = -1; prev_k_cyc = -1;
        gap_err = 0; word_idx = 0; tog = 1'b0; first_addr = '0;
        exp_q.delete();
    endtask

    // Expected write stream: {int_mem_we, overlap_cache_we, b_zero, data, addr}.
    task automatic build_expected(input logic [7:0] vr, input logic op);
        int          k;
        logic        pad;
        logic [15:0] a;
        k = 0;
        exp_q.delete();
        for (int ic = 0; ic < IN_CH; ic++)
            for (int ky = 0; ky < KS; ky++)
                for (int kx = 0; kx < KS; kx++)
                    for (int oc = 0; oc < OUT_CH; oc++) begin
                        a = 16'h8000 | 16'((ic << 8) | (ky << 6) | (kx << 4) | oc);
                        exp_q.push_back({1'b1, 1'b0, 1'b0, word(k), a});
                        k++;
                    end
        for (int ic = 0; ic < IN_CH; ic++)
            for (int y = 0; y < TH; y++)
                for (int x = 0; x < TW; x++) begin
                    a   = 16'((ic << 13) | (y << 6) | x);
                    pad = (y >= int'(vr));
                    if (pad) exp_q.push_back({1'b1, 1'b0, 1'b1, 16'h0000, a});
                    else begin
                        exp_q.push_back({1'b1, 1'b0, 1'b0, word(k), a});
                        k++;
                    end
                end
        for (int ic = 0; ic < IN_CH; ic++)
            for (int y = 0; y < TH; y++) begin
                a   = 16'((ic << 7) | y);
                pad = (y >= int'(vr)) || !op;
                if (pad) exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0000, a});
                else begin
                    exp_q.push_back({1'b0, 1'b1, 1'b0, word(k), a});
                    k++;
                end
            end
    endtask

    // One cycle: observe outputs at the falling edge, then present the source for the next rise.
    task automatic tick();
        logic [34:0] got;
        @(negedge clk);
        cyc++;
        if (int_mem_we || overlap_cache_we) begin
            got = {int_mem_we, overlap_cache_we, b_zero, b_input, a_input};
            if (n_writes == 0) first_addr = a_input;
            n_writes++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (overlap_cache_we) n_overlap_wr++;
            if (int_mem_we && !a_input[15]) n_input_wr++;
            if (tog_mode && int_mem_we && a_input[15]) begin
                if (prev_k_cyc >= 0 && (cyc - prev_k_cyc) != 2) gap_err++;
                prev_k_cyc = cyc;
            end
            if (exp_q.size() == 0) check("unexpected_write", 64'(got), 64'd0);
            else check("write", 64'(got), 64'(exp_q.pop_front()));
        end
        if (data_ready && dr_cyc < 0) dr_cyc = cyc;
        if (tog_mode) begin
            tog = ~tog;
            src_valid = tog;
        end else begin
            src_valid = 1'b1;
        end
        src_data = word(word_idx);
        if (src_valid && src_ready) word_idx++;
    endtask

    task automatic run_tile(input string name, input logic [7:0] vr, input logic op,
                            input bit tg, input bit poke, input int spec_words);
        arm();
        tog_mode = tg;
        build_expected(vr, op);
        valid_rows = vr; overlap_present = op; start = 1'b1;
        tick();
        start = 1'b0;
        // Changing these after the accepted start must not affect the tile.
        valid_rows = ~vr; overlap_present = ~op;
        for (int i = 0; i < 40000 && dr_cyc < 0; i++) begin
            if (poke) begin
                start    = (i == 2000);
                fsm_done = (i == 3000);
            end
            tick();
        end
        start = 1'b0; fsm_done = 1'b0;
        check({name, "_data_ready_seen"}, 64'(dr_cyc >= 0), 64'd1);
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check({name, "_words"}, 64'(word_idx), 64'(spec_words));
        check({name, "_writes"}, 64'(n_writes), 64'd16928);
        check({name, "_overlap_we"}, 64'(n_overlap_wr), 64'd256);
        check({name, "_dr_latency"}, 64'(dr_cyc - last_wr), 64'd1);
        if (!tg) check({name, "_span"}, 64'(last_wr - first_wr + 1), 64'd16928);
        else check({name, "_kernel_gap"}, 64'(gap_err), 64'd0);
        repeat (3) tick();
        check({name, "_dr_hold"}, 64'(data_ready), 64'd1);
        check({name, "_busy_ready"}, 64'(busy), 64'd1);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        check({name, "_dr_drop"}, 64'(data_ready), 64'd0);
        check({name, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    task automatic reset_test();
        arm();
        tog_mode = 1'b0;
        build_expected(8'd128, 1'b1);
        valid_rows = 8'd128; overlap_present = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10000 && n_input_wr < 5000; i++) tick();
        check("rst_reach_5000", 64'(n_input_wr), 64'd5000);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({int_mem_we, overlap_cache_we, b_zero}), 64'd0);
        check("rst_a_input", 64'(a_input), 64'd0);
        check("rst_b_input", 64'(b_input), 64'd0);
        check("rst_ready_flags", 64'({data_ready, src_ready}), 64'd0);
        exp_q.delete();
        tick();
        check("rst_no_strobe", 64'({int_mem_we, overlap_cache_we}), 64'd0);
        arm();
        build_expected(8'd128, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && n_writes == 0; i++) tick();
        check("reload_first_addr", 64'(first_addr), 64'h8000);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b0; fsm_done = 1'b0;
        valid_rows = '0; overlap_present = 1'b0;
        src_valid = 1'b0; src_data = '0;
        tog_mode = 1'b0;
        arm();
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data_ready", 64'(data_ready), 64'd0);
        check("reset_src_ready", 64'(src_ready), 64'd0);
        check("reset_strobes", 64'({int_mem_we, overlap_cache_we, b_zero}), 64'd0);
        check("reset_a_input", 64'(a_input), 64'd0);
        check("reset_b_input", 64'(b_input), 64'd0);
        rst_in = 1'b0;
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        check("idle_fsm_done_ignored", 64'(busy), 64'd0);

        run_tile("full",   8'd128, 1'b1, 1'b0, 1'b1, 16928);
        run_tile("rowpad", 8'd100, 1'b1, 1'b0, 1'b0, 13288);
        run_tile("noovl",  8'd128, 1'b0, 1'b0, 1'b0, 16672);
        run_tile("bp",     8'd0,   1'b1, 1'b1, 1'b0, 288);
        reset_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
